// File: rtl/spi_pkg.sv
// Shared constants and state encoding for the SPI master shift engine.
package spi_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned DVSR_W = 16;
    localparam int unsigned BIT_W  = $clog2(DATA_W);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        CPHA_DELAY = 2'd1,
        P0         = 2'd2,
        P1         = 2'd3
    } spi_state_t;

endpackage

// File: rtl/spi_master_engine.sv
// Byte-wide SPI master: shifts din out on mosi, captures miso, generates sclk.
// Optional LSB-first transfers are enabled with the SPI_LSB_FIRST_EN macro.
module spi_master_engine
    import spi_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] din,
    input  logic [DVSR_W-1:0] dvsr,
    input  logic              start,
    input  logic              cpol,
    input  logic              cpha,
`ifdef SPI_LSB_FIRST_EN
    input  logic              lsb_first,
`endif
    output logic [DATA_W-1:0] dout,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso,
    output logic              done_tick,
    output logic              ready
);

    spi_state_t        state_q, state_d;
    logic [DATA_W-1:0] tx_q, tx_d;
    logic [DATA_W-1:0] rx_q, rx_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [DVSR_W-1:0] cnt_q, cnt_d;
    logic [DVSR_W-1:0] dvsr_q, dvsr_d;
    logic              cpol_q, cpol_d;
    logic              cpha_q, cpha_d;
    logic              sclk_d, mosi_d, done_d, ready_d;
    logic              half_end;
    logic              p_clk;
`ifdef SPI_LSB_FIRST_EN
    logic              lsb_q, lsb_d;
`endif

    assign dout = rx_q;

    // State and datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            tx_q      <= '0;
            rx_q      <= '0;
            bit_q     <= '0;
            cnt_q     <= '0;
            dvsr_q    <= '0;
            cpol_q    <= 1'b0;
            cpha_q    <= 1'b0;
            sclk      <= 1'b0;
            mosi      <= 1'b0;
            done_tick <= 1'b0;
            ready     <= 1'b1;
`ifdef SPI_LSB_FIRST_EN
            lsb_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            bit_q     <= bit_d;
            cnt_q     <= cnt_d;
            dvsr_q    <= dvsr_d;
            cpol_q    <= cpol_d;
            cpha_q    <= cpha_d;
            sclk      <= sclk_d;
            mosi      <= mosi_d;
            done_tick <= done_d;
            ready     <= ready_d;
`ifdef SPI_LSB_FIRST_EN
            lsb_q     <= lsb_d;
`endif
        end
    end

    // Next-state, datapath and output decode
    always_comb begin
        state_d  = state_q;
        tx_d     = tx_q;
        rx_d     = rx_q;
        bit_d    = bit_q;
        cnt_d    = cnt_q;
        dvsr_d   = dvsr_q;
        cpol_d   = cpol_q;
        cpha_d   = cpha_q;
        done_d   = 1'b0;
        half_end = (cnt_q == dvsr_q);
`ifdef SPI_LSB_FIRST_EN
        lsb_d    = lsb_q;
`endif

        case (state_q)
            IDLE: begin
                // sclk tracks the live polarity while idle
                cpol_d = cpol;
                if (start) begin
                    tx_d    = din;
                    dvsr_d  = dvsr;
                    cpha_d  = cpha;
                    bit_d   = '0;
                    cnt_d   = '0;
`ifdef SPI_LSB_FIRST_EN
                    lsb_d   = lsb_first;
`endif
                    state_d = cpha ? CPHA_DELAY : P0;
                end
            end
            CPHA_DELAY: begin
                if (half_end) begin
                    cnt_d   = '0;
                    state_d = P0;
                end else begin
                    cnt_d = cnt_q + DVSR_W'(1);
                end
            end
            P0: begin
                if (half_end) begin
                    cnt_d   = '0;
`ifdef SPI_LSB_FIRST_EN
                    rx_d    = lsb_q ? {miso, rx_q[DATA_W-1:1]} : {rx_q[DATA_W-2:0], miso};
`else
                    rx_d    = {rx_q[DATA_W-2:0], miso};
`endif
                    state_d = P1;
                end else begin
                    cnt_d = cnt_q + DVSR_W'(1);
                end
            end
            P1: begin
                if (half_end) begin
                    cnt_d = '0;
                    if (bit_q == BIT_W'(DATA_W - 1)) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
`ifdef SPI_LSB_FIRST_EN
                        tx_d = lsb_q ? {1'b0, tx_q[DATA_W-1:1]} : {tx_q[DATA_W-2:0], 1'b0};
`else
                        tx_d = {tx_q[DATA_W-2:0], 1'b0};
`endif
                        bit_d   = bit_q + BIT_W'(1);
                        state_d = P0;
                    end
                end else begin
                    cnt_d = cnt_q + DVSR_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from next state so they align with the state register
        p_clk   = ((state_d == P1) && !cpha_d) || ((state_d == P0) && cpha_d);
        sclk_d  = p_clk ^ cpol_d;
        ready_d = (state_d == IDLE);
`ifdef SPI_LSB_FIRST_EN
        mosi_d  = lsb_d ? tx_d[0] : tx_d[DATA_W-1];
`else
        mosi_d  = tx_d[DATA_W-1];
`endif
    end

endmodule

// File: tb/tb_spi_master_engine.sv
// Scoreboard bench for spi_master_engine: directed transfers, expected results queued at issue.
module tb_spi_master_engine;

    logic        clk;
    logic        reset_n;
    logic [7:0]  din;
    logic [15:0] dvsr;
    logic        start;
    logic        cpol;
    logic        cpha;
    logic [7:0]  dout;
    logic        sclk;
    logic        mosi;
    logic        miso;
    logic        done_tick;
    logic        ready;
    logic        loop;
    logic        miso_hold;
`ifdef SPI_LSB_FIRST_EN
    logic        lsb_first;
`endif

    typedef struct {
        logic [7:0]  dout;
        int unsigned cyc;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned cyc = 0;
    int unsigned n_cmp = 0;
    int unsigned n_fail = 0;
    int unsigned done_cnt = 0;
    int unsigned rise_cnt = 0;
    int unsigned trans_cnt = 0;
    logic        sclk_prev = 1'b0;
    logic [7:0]  mosi_seq = 8'h00;
    int unsigned rise_base, trans_base, done_base;

    assign miso = loop ? mosi : miso_hold;

    spi_master_engine dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .din       (din),
        .dvsr      (dvsr),
        .start     (start),
        .cpol      (cpol),
        .cpha      (cpha),
`ifdef SPI_LSB_FIRST_EN
        .lsb_first (lsb_first),
`endif
        .dout      (dout),
        .sclk      (sclk),
        .mosi      (mosi),
        .miso      (miso),
        .done_tick (done_tick),
        .ready     (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pop expected result on every done_tick
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (reset_n === 1'b1 && done_tick === 1'b1) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_done: done_tick with empty scoreboard at cycle %0d", cyc);
            end else begin
                e = exp_q.pop_front();
                check("dout", 32'(dout), 32'(e.dout));
                check("done_cycle", cyc, e.cyc);
                check("ready_at_done", 32'(ready), 32'd1);
            end
        end
    end

    // sclk edge counting; mosi captured on each leading edge
    initial forever begin
        @(negedge clk);
        if (sclk !== sclk_prev) begin
            trans_cnt++;
            if (sclk === 1'b1) rise_cnt++;
            if (sclk !== cpol) mosi_seq = {mosi_seq[6:0], mosi};
        end
        sclk_prev = sclk;
    end

    task automatic issue(input logic [7:0] d, input logic [15:0] dv, input logic pol,
                         input logic pha, input bit push, input logic [7:0] exp_d);
        exp_t        e;
        int unsigned h;
        h     = int'(dv) + 1;
        din   = d;
        dvsr  = dv;
        cpol  = pol;
        cpha  = pha;
        start = 1'b1;
        if (push) begin
            e.dout = exp_d;
            e.cyc  = cyc + 1 + (pha ? 17 * h : 16 * h);
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check("busy_cycle1", 32'(ready), 32'd0);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 3000 && exp_q.size() != 0; i++) @(negedge clk);
        check("drain", 32'(exp_q.size()), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic snapshot();
        rise_base  = rise_cnt;
        trans_base = trans_cnt;
        done_base  = done_cnt;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b1; start = 1'b0; din = 8'h00; dvsr = 16'd0;
        cpol = 1'b0; cpha = 1'b0; loop = 1'b0; miso_hold = 1'b0;
`ifdef SPI_LSB_FIRST_EN
        lsb_first = 1'b0;
`endif
        #1 reset_n = 1'b0;
        #1;
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_done", 32'(done_tick), 32'd0);
        check("rst_sclk", 32'(sclk), 32'd0);
        check("rst_mosi", 32'(mosi), 32'd0);
        check("rst_dout", 32'(dout), 32'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Mode 0, dvsr=1, loopback A5
        loop = 1'b1;
        snapshot();
        issue(8'hA5, 16'd1, 1'b0, 1'b0, 1'b1, 8'hA5);
        wait_drain();
        check("t1_rises", rise_cnt - rise_base, 32'd8);
        check("t1_trans", trans_cnt - trans_base, 32'd16);
        check("t1_sclk_idle", 32'(sclk), 32'd0);
        check("t1_mosi_seq", 32'(mosi_seq), 32'hA5);

        // Mode 3, dvsr=0, miso held high
        loop = 1'b0; miso_hold = 1'b1; cpol = 1'b1;
        repeat (3) @(negedge clk);
        check("t2_sclk_idle_hi", 32'(sclk), 32'd1);
        snapshot();
        issue(8'h3C, 16'd0, 1'b1, 1'b1, 1'b1, 8'hFF);
        wait_drain();
        check("t2_trans", trans_cnt - trans_base, 32'd16);
        check("t2_sclk_end", 32'(sclk), 32'd1);
        check("t2_mosi_seq", 32'(mosi_seq), 32'h3C);

        // Stray start during bit 3 is ignored
        loop = 1'b1; cpol = 1'b0;
        repeat (3) @(negedge clk);
        snapshot();
        issue(8'h96, 16'd1, 1'b0, 1'b0, 1'b1, 8'h96);
        repeat (12) @(negedge clk);
        din = 8'h00; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_drain();
        repeat (40) @(negedge clk);
        check("t3_done_count", done_cnt - done_base, 32'd1);

        // Asynchronous reset at bit 4 of a cpol=1 transfer
        cpol = 1'b1;
        repeat (3) @(negedge clk);
        issue(8'hFF, 16'd1, 1'b1, 1'b0, 1'b0, 8'h00);
        repeat (17) @(negedge clk);
        check("t4_busy", 32'(ready), 32'd0);
        #2 reset_n = 1'b0;
        #1;
        check("t4_ready", 32'(ready), 32'd1);
        check("t4_sclk", 32'(sclk), 32'd0);
        check("t4_mosi", 32'(mosi), 32'd0);
        check("t4_dout", 32'(dout), 32'd0);
        check("t4_done", 32'(done_tick), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        cpol = 1'b0;
        repeat (3) @(negedge clk);

        // Back-to-back: second start in the done_tick cycle
        issue(8'hC3, 16'd2, 1'b0, 1'b1, 1'b1, 8'hC3);
        for (int i = 0; i < 200 && done_tick !== 1'b1; i++) @(negedge clk);
        check("t5_done_seen", 32'(done_tick), 32'd1);
        issue(8'h5A, 16'd2, 1'b0, 1'b1, 1'b1, 8'h5A);
        wait_drain();

        // Bit order on the first mosi bit
`ifdef SPI_LSB_FIRST_EN
        lsb_first = 1'b1;
`endif
        issue(8'h01, 16'd0, 1'b0, 1'b0, 1'b1, 8'h01);
`ifdef SPI_LSB_FIRST_EN
        check("t6_first_mosi", 32'(mosi), 32'd1);
`else
        check("t6_first_mosi", 32'(mosi), 32'd0);
`endif
        wait_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
